perf_monitor: RTL and testbench

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_monitor.sv | 132 +++++++++++++
 tb/tb_perf_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// Event-count performance monitor with a run/pause/done sequencer and a
// snapshot readout engine that streams one channel per ready/valid handshake.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i; counters hold, events ignored
// RUN   | counting while start_i is high, paused while it is low
// DONE  | run length reached; counters frozen until clear_i
module perf_monitor #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int SATURATE   = 0,
  parameter int MAX_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              snap_i,
  output logic              rd_valid_o,
  output logic [3:0]        rd_ch_o,
  output logic [CNT_W-1:0]  rd_data_o,
  input  logic              rd_ready_i,
  output logic [CNT_W-1:0]  cycle_o,
  output logic              done_o,
  output logic              overrun_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
  localparam logic [CH_W-1:0]  LAST  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_nx   [NUM_CH];
  logic [CNT_W-1:0] shadow_q [NUM_CH];
  logic [CNT_W-1:0] cycle_q, cycle_nx;
  logic [CH_W-1:0]  rd_idx;
  logic             busy, overrun;
  logic             counting, to_done, snap_req;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (SATURATE != 0 && (&v)) return v;
    return v + ONE;
  endfunction

  always_comb begin
    counting = (state == S_RUN) && start_i;
    cycle_nx = counting ? bump(cycle_q) : cycle_q;
    for (int k = 0; k < NUM_CH; k++)
      cnt_nx[k] = (counting && event_i[k]) ? bump(cnt_q[k]) : cnt_q[k];
    to_done  = counting && (MAX_CYCLES != 0) && (cycle_nx == MAX_C);
    snap_req = (snap_i && (state != S_IDLE)) || to_done;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_i) state_nx = S_RUN;
      S_RUN:   if (to_done) state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (clear_i) state_nx = S_IDLE;
  end

  // Release is inherently edge-aligned: every flop only leaves reset on a
  // clock edge, so the first edge after release may already leave IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_q <= '0;
      busy    <= 1'b0;
      rd_idx  <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else if (clear_i) begin
      cycle_q <= '0;
      busy    <= 1'b0;
      rd_idx  <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cnt_q[k]    <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      cycle_q <= cycle_nx;
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_nx[k];
      if (snap_req && !busy) begin
        // The end-of-run snapshot records the final totals, including the
        // last counted cycle; a user snapshot records pre-edge values.
        for (int k = 0; k < NUM_CH; k++)
          shadow_q[k] <= to_done ? cnt_nx[k] : cnt_q[k];
        busy   <= 1'b1;
        rd_idx <= '0;
      end else if (busy && rd_ready_i) begin
        if (rd_idx == LAST) begin
          busy   <= 1'b0;
          rd_idx <= '0;
        end else begin
          rd_idx <= rd_idx + CH_W'(1);
        end
      end
      if (snap_req && busy) overrun <= 1'b1;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (busy)
      for (int k = 0; k < NUM_CH; k++)
        if (rd_idx == CH_W'(k)) rd_data_o = shadow_q[k];
  end

  assign rd_valid_o = busy;
  assign rd_ch_o    = 4'(rd_idx);
  assign cycle_o    = cycle_q;
  assign done_o     = (state == S_DONE);
  assign overrun_o  = overrun;

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor: default instance plus two 8-bit
// unlimited-run instances (wrapping and saturating) sharing one stimulus.
module tb_perf_monitor;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i, start_i, clear_i, snap_i, rd_ready_i;
  logic [3:0]  event_i;
  logic        rd_valid_o, done_o, overrun_o;
  logic [3:0]  rd_ch_o;
  logic [31:0] rd_data_o, cycle_o;

  logic        start8, clear8, snap8, ready8;
  logic [3:0]  ev8;
  logic        vw, donew, ovw, vs, dones, ovs;
  logic [3:0]  chw, chs;
  logic [7:0]  dw, cw, ds, cs;

  int total = 0;
  int bad   = 0;

  perf_monitor dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .event_i(event_i), .snap_i(snap_i), .rd_valid_o(rd_valid_o),
    .rd_ch_o(rd_ch_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .cycle_o(cycle_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  perf_monitor #(.CNT_W(8), .SATURATE(0), .MAX_CYCLES(0)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start8), .clear_i(clear8),
    .event_i(ev8), .snap_i(snap8), .rd_valid_o(vw),
    .rd_ch_o(chw), .rd_data_o(dw), .rd_ready_i(ready8),
    .cycle_o(cw), .done_o(donew), .overrun_o(ovw)
  );

  perf_monitor #(.CNT_W(8), .SATURATE(1), .MAX_CYCLES(0)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start8), .clear_i(clear8),
    .event_i(ev8), .snap_i(snap8), .rd_valid_o(vs),
    .rd_ch_o(chs), .rd_data_o(ds), .rd_ready_i(ready8),
    .cycle_o(cs), .done_o(dones), .overrun_o(ovs)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_rd(input string tag, input int ch, input logic [31:0] val);
    chk($sformatf("%s_valid", tag), {63'd0, rd_valid_o}, 64'd1);
    chk($sformatf("%s_ch", tag), {60'd0, rd_ch_o}, 64'(ch));
    chk($sformatf("%s_data", tag), {32'd0, rd_data_o}, {32'd0, val});
  endtask

  initial begin
    int n;
    rst_i = 1'b1; start_i = 1'b0; clear_i = 1'b0; snap_i = 1'b0;
    rd_ready_i = 1'b0; event_i = 4'd0;
    start8 = 1'b0; clear8 = 1'b0; snap8 = 1'b0; ready8 = 1'b0; ev8 = 4'd0;

    // reset state, observed before any clock edge
    #2 rst_i = 1'b0;
    #1;
    chk("rst_valid", {63'd0, rd_valid_o}, 64'd0);
    chk("rst_ch", {60'd0, rd_ch_o}, 64'd0);
    chk("rst_data", {32'd0, rd_data_o}, 64'd0);
    chk("rst_cycle", {32'd0, cycle_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_ovr", {63'd0, overrun_o}, 64'd0);
    tick();
    tick();
    #3 rst_i = 1'b1;

    // full run: ev[0] held high, done after 64 counted cycles
    start_i = 1'b1; event_i = 4'b0001; rd_ready_i = 1'b1;
    n = 0;
    while (!done_o && n < 200) begin
      tick();
      n++;
    end
    chk("run_edges", 64'(n), 64'd65);
    chk("run_cycle", {32'd0, cycle_o}, 64'd64);
    chk_rd("auto0", 0, 32'd64);
    tick(); chk_rd("auto1", 1, 32'd0);
    tick(); chk_rd("auto2", 2, 32'd0);
    tick(); chk_rd("auto3", 3, 32'd0);
    tick();
    chk("auto_end_valid", {63'd0, rd_valid_o}, 64'd0);
    chk("auto_end_data", {32'd0, rd_data_o}, 64'd0);
    chk("done_hold", {63'd0, done_o}, 64'd1);
    chk("done_cycle_hold", {32'd0, cycle_o}, 64'd64);

    // clear in DONE
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("clr_done", {63'd0, done_o}, 64'd0);
    chk("clr_cycle", {32'd0, cycle_o}, 64'd0);

    // start and clear together in IDLE: clear wins
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("clr_start_c0", {32'd0, cycle_o}, 64'd0);
    tick();
    chk("clr_start_c1", {32'd0, cycle_o}, 64'd0);
    tick();
    chk("clr_start_c2", {32'd0, cycle_o}, 64'd1);

    // pause scenario: 5 pulses on ev[1], 3 paused cycles
    start_i = 1'b0; event_i = 4'd0;
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    start_i = 1'b1;
    tick();
    chk("p_enter", {32'd0, cycle_o}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      event_i = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
    end
    event_i = 4'd0;
    chk("p_cyc10", {32'd0, cycle_o}, 64'd10);
    start_i = 1'b0;
    event_i = 4'b0010;
    repeat (3) tick();
    event_i = 4'd0;
    chk("p_hold", {32'd0, cycle_o}, 64'd10);
    start_i = 1'b1;
    repeat (4) tick();
    chk("p_cyc14", {32'd0, cycle_o}, 64'd14);
    start_i = 1'b0; snap_i = 1'b1; tick(); snap_i = 1'b0;
    chk_rd("ps0", 0, 32'd0);
    tick(); chk_rd("ps1", 1, 32'd5);
    tick(); chk_rd("ps2", 2, 32'd0);
    tick(); chk_rd("ps3", 3, 32'd0);
    tick();
    chk("ps_end", {63'd0, rd_valid_o}, 64'd0);

    // stalled readout and overrun; snapshot excludes same-edge event
    start_i = 1'b1; event_i = 4'b0001; rd_ready_i = 1'b0;
    tick(); tick();
    snap_i = 1'b1; tick(); snap_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_rd($sformatf("stall%0d", i), 0, 32'd2);
      if (i == 0) chk("ovr_before", {63'd0, overrun_o}, 64'd0);
      snap_i = (i == 4);
      tick();
    end
    snap_i = 1'b0;
    chk("ovr_set", {63'd0, overrun_o}, 64'd1);
    rd_ready_i = 1'b1;
    tick(); chk_rd("dr1", 1, 32'd5);
    tick(); chk_rd("dr2", 2, 32'd0);
    tick(); chk_rd("dr3", 3, 32'd0);
    tick();
    chk("dr_end", {63'd0, rd_valid_o}, 64'd0);
    chk("ovr_sticky", {63'd0, overrun_o}, 64'd1);

    // async reset mid-readout, between edges
    rd_ready_i = 1'b0; snap_i = 1'b1; tick(); snap_i = 1'b0;
    chk("pre_rst_valid", {63'd0, rd_valid_o}, 64'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_valid", {63'd0, rd_valid_o}, 64'd0);
    chk("arst_data", {32'd0, rd_data_o}, 64'd0);
    chk("arst_cycle", {32'd0, cycle_o}, 64'd0);
    chk("arst_ovr", {63'd0, overrun_o}, 64'd0);
    #2 rst_i = 1'b1;
    start_i = 1'b1; event_i = 4'd0; rd_ready_i = 1'b1;
    tick();
    chk("rel_c0", {32'd0, cycle_o}, 64'd0);
    tick();
    chk("rel_c1", {32'd0, cycle_o}, 64'd1);
    start_i = 1'b0; snap_i = 1'b1; tick(); snap_i = 1'b0;
    chk_rd("rz0", 0, 32'd0);
    tick(); chk_rd("rz1", 1, 32'd0);
    tick(); chk_rd("rz2", 2, 32'd0);
    tick(); chk_rd("rz3", 3, 32'd0);

    // 8-bit wrap vs saturate, 260 counted cycles on ev[2]
    start8 = 1'b1; ev8 = 4'b0100; ready8 = 1'b1;
    tick();
    repeat (260) tick();
    start8 = 1'b0; ev8 = 4'd0;
    chk("w_cycle", {56'd0, cw}, 64'd4);
    chk("s_cycle", {56'd0, cs}, 64'd255);
    chk("w_done", {63'd0, donew}, 64'd0);
    chk("s_done", {63'd0, dones}, 64'd0);
    snap8 = 1'b1; tick(); snap8 = 1'b0;
    chk("w_ch0", {56'd0, dw}, 64'd0);
    tick();
    chk("w_ch1", {56'd0, dw}, 64'd0);
    tick();
    chk("w_idx2", {60'd0, chw}, 64'd2);
    chk("s_idx2", {60'd0, chs}, 64'd2);
    chk("w_ch2", {56'd0, dw}, 64'd4);
    chk("s_ch2", {56'd0, ds}, 64'd255);
    chk("w_valid2", {63'd0, vw}, 64'd1);
    tick(); tick();
    chk("w_end", {63'd0, vw}, 64'd0);
    chk("s_end", {63'd0, vs}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
